gtech_stream_mux: RTL and testbench

GTECH_STREAM_MUX -- requirements
Module: gtech_stream_mux

---
 rtl/gtech_stream_mux.sv | 147 ++++++++++++++
 tb/tb_gtech_stream_mux.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gtech_stream_mux.sv
// N-channel packet-aware stream multiplexer with a registered output stage.
// A packet holds its channel from first accepted beat until its LAST beat.
module gtech_stream_mux #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int MODE = 1
) (
    input  logic                 CP,
    input  logic                 CD,
    input  logic [$clog2(N)-1:0] SEL,
    input  logic [N*W-1:0]       IN_DATA,
    input  logic [N-1:0]         IN_VALID,
    input  logic [N-1:0]         IN_LAST,
    output logic [N-1:0]         IN_READY,
    output logic [W-1:0]         OUT_DATA,
    output logic                 OUT_LAST,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [N-1:0]         GRANT,
    output logic                 BUSY
);

    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  g_q, g_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_last_q, out_last_d;
    logic           out_valid_q, out_valid_d;

    logic           le;
    logic           cand_vld;
    logic [IW-1:0]  cand_idx;
    logic           cand_in_valid;
    logic           cand_in_last;
    logic [W-1:0]   cand_data;
    logic           accept;

    assign le = ~out_valid_q | OUT_READY;

    // Candidate selection: the locked channel wins outright; otherwise SEL
    // or a cyclic search starting just after the last channel to finish.
    always_comb begin
        int unsigned idx;
        cand_vld = 1'b0;
        cand_idx = '0;
        idx      = 0;
        if (state_q == LOCK) begin
            cand_vld = 1'b1;
            cand_idx = g_q;
        end else if (MODE == 0) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (SEL == IW'(i) && IN_VALID[i]) begin
                    cand_vld = 1'b1;
                    cand_idx = IW'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= N; k++) begin
                idx = (32'(ptr_q) + k) % 32'(N);
                if (!cand_vld && IN_VALID[IW'(idx)]) begin
                    cand_vld = 1'b1;
                    cand_idx = IW'(idx);
                end
            end
        end
    end

    always_comb begin
        cand_in_valid = 1'b0;
        cand_in_last  = 1'b0;
        cand_data     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cand_idx == IW'(i)) begin
                cand_in_valid = IN_VALID[i];
                cand_in_last  = IN_LAST[i];
                cand_data     = IN_DATA[i*W +: W];
            end
        end
    end

    assign accept = cand_vld & le & cand_in_valid;

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            state_q     <= IDLE;
            g_q         <= '0;
            ptr_q       <= IW'(N - 1);
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (le) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d = cand_data;
                out_last_d = cand_in_last;
            end
        end
        if (accept) begin
            if (cand_in_last) begin
                state_d = IDLE;
                ptr_d   = cand_idx;
            end else begin
                state_d = LOCK;
                g_d     = cand_idx;
            end
        end
    end

    // IN_READY is gated by CD so it drops the instant reset asserts.
    always_comb begin
        IN_READY = '0;
        if (CD && cand_vld && le) begin
            IN_READY[cand_idx] = 1'b1;
        end
        GRANT = '0;
        if (state_q == LOCK) begin
            GRANT[g_q] = 1'b1;
        end
        BUSY = (state_q == LOCK) | out_valid_q;
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_LAST  = out_last_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_gtech_stream_mux.sv
// Bench for gtech_stream_mux: a round-robin instance (N=4) and a SEL-driven
// instance (N=5, so an out-of-range SEL is representable), both model-checked.
module tb_gtech_stream_mux;

    logic CP = 1'b0;
    logic CD;
    always #5 CP = ~CP;

    logic [1:0]  sel_a;
    logic [31:0] data_a;
    logic [3:0]  vld_a, last_a, rdy_a, grant_a;
    logic [7:0]  od_a;
    logic        ol_a, ov_a, ordy_a, busy_a;

    logic [2:0]  sel_b;
    logic [39:0] data_b;
    logic [4:0]  vld_b, last_b, rdy_b, grant_b;
    logic [7:0]  od_b;
    logic        ol_b, ov_b, ordy_b, busy_b;

    gtech_stream_mux #(.W(8), .N(4), .MODE(1)) dut (
        .CP(CP), .CD(CD), .SEL(sel_a), .IN_DATA(data_a), .IN_VALID(vld_a),
        .IN_LAST(last_a), .IN_READY(rdy_a), .OUT_DATA(od_a), .OUT_LAST(ol_a),
        .OUT_VALID(ov_a), .OUT_READY(ordy_a), .GRANT(grant_a), .BUSY(busy_a)
    );

    gtech_stream_mux #(.W(8), .N(5), .MODE(0)) dut_sel (
        .CP(CP), .CD(CD), .SEL(sel_b), .IN_DATA(data_b), .IN_VALID(vld_b),
        .IN_LAST(last_b), .IN_READY(rdy_b), .OUT_DATA(od_b), .OUT_LAST(ol_b),
        .OUT_VALID(ov_b), .OUT_READY(ordy_b), .GRANT(grant_b), .BUSY(busy_b)
    );

    // Reference model: locked channel (-1 = none), rotation pointer, output register.
    int         m_lock[2];
    int         m_ptr[2];
    logic       m_ov[2];
    logic       m_ol[2];
    logic [7:0] m_od[2];

    int checks = 0;
    int errors = 0;

    function automatic int nch(int u);
        return (u == 0) ? 4 : 5;
    endfunction

    function automatic logic vld(int u, int i);
        return (u == 0) ? vld_a[i] : vld_b[i];
    endfunction

    function automatic logic lst(int u, int i);
        return (u == 0) ? last_a[i] : last_b[i];
    endfunction

    function automatic logic [7:0] dat(int u, int i);
        return (u == 0) ? data_a[i*8 +: 8] : data_b[i*8 +: 8];
    endfunction

    function automatic logic ordy(int u);
        return (u == 0) ? ordy_a : ordy_b;
    endfunction

    function automatic int cand(int u);
        int n;
        n = nch(u);
        if (m_lock[u] >= 0) return m_lock[u];
        if (u == 1) begin
            if (int'(sel_b) < n && vld(1, int'(sel_b))) return int'(sel_b);
            return -1;
        end
        for (int k = 1; k <= n; k++) begin
            if (vld(u, (m_ptr[u] + k) % n)) return (m_ptr[u] + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_lock[u] = -1;
            m_ptr[u]  = nch(u) - 1;
            m_ov[u]   = 1'b0;
            m_ol[u]   = 1'b0;
            m_od[u]   = 8'h00;
        end
    endtask

    task automatic model_step();
        if (CD !== 1'b1) begin
            model_reset();
        end else begin
            for (int u = 0; u < 2; u++) begin
                int   c;
                logic le;
                c  = cand(u);
                le = !m_ov[u] || ordy(u);
                if (le) begin
                    if (c >= 0 && vld(u, c)) begin
                        m_ov[u] = 1'b1;
                        m_od[u] = dat(u, c);
                        m_ol[u] = lst(u, c);
                        if (lst(u, c)) begin
                            m_lock[u] = -1;
                            m_ptr[u]  = c;
                        end else begin
                            m_lock[u] = c;
                        end
                    end else begin
                        m_ov[u] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_now();
        for (int u = 0; u < 2; u++) begin
            int          c;
            logic        le;
            logic [63:0] er, eg;
            c  = cand(u);
            le = !m_ov[u] || ordy(u);
            er = '0;
            if (CD === 1'b1 && le && c >= 0) er[c] = 1'b1;
            eg = '0;
            if (m_lock[u] >= 0) eg[m_lock[u]] = 1'b1;
            chk($sformatf("in_ready[%0d]", u), (u == 0) ? 64'(rdy_a) : 64'(rdy_b), er);
            chk($sformatf("grant[%0d]", u), (u == 0) ? 64'(grant_a) : 64'(grant_b), eg);
            chk($sformatf("busy[%0d]", u), (u == 0) ? 64'(busy_a) : 64'(busy_b),
                64'(m_lock[u] >= 0 || m_ov[u]));
            chk($sformatf("out_valid[%0d]", u), (u == 0) ? 64'(ov_a) : 64'(ov_b), 64'(m_ov[u]));
            chk($sformatf("out_data[%0d]", u), (u == 0) ? 64'(od_a) : 64'(od_b), 64'(m_od[u]));
            chk($sformatf("out_last[%0d]", u), (u == 0) ? 64'(ol_a) : 64'(ol_b), 64'(m_ol[u]));
        end
    endtask

    task automatic tick();
        @(posedge CP);
        model_step();
        #2;
    endtask

    task automatic apply();
        #1;
        check_now();
    endtask

    task automatic cyc();
        apply();
        tick();
    endtask

    logic [7:0] rr_exp [5];

    initial begin
        rr_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        CD = 1'b0;
        sel_a = '0; data_a = '0; vld_a = '0; last_a = '0; ordy_a = 1'b0;
        sel_b = '0; data_b = '0; vld_b = '0; last_b = '0; ordy_b = 1'b0;
        model_reset();
        apply();
        tick();
        tick();

        // Reset release with every channel offering single-beat packets.
        data_a = {8'h13, 8'h12, 8'h11, 8'h10};
        vld_a = 4'hF; last_a = 4'hF; ordy_a = 1'b1; ordy_b = 1'b1;
        CD = 1'b1;
        apply();
        chk("rr_first_ready", 64'(rdy_a), 64'h1);
        chk("rr_valid_before_edge", 64'(ov_a), 64'h0);
        tick();
        chk("rr_valid_after_edge", 64'(ov_a), 64'h1);
        chk("rr_out0", 64'(od_a), 64'(rr_exp[0]));
        for (int i = 1; i < 5; i++) begin
            cyc();
            chk($sformatf("rr_out%0d", i), 64'(od_a), 64'(rr_exp[i]));
        end

        // Three-beat packet on ch2 while ch0 also waits.
        vld_a = 4'b0101; last_a = 4'b0000;
        data_a = {8'h00, 8'hA0, 8'h00, 8'h5A};
        apply();
        chk("lock_ready_a0", 64'(rdy_a), 64'h4);
        tick();
        chk("lock_out_a0", 64'(od_a), 64'hA0);
        data_a[23:16] = 8'hA1;
        apply();
        chk("lock_grant_a1", 64'(grant_a), 64'h4);
        chk("lock_ready_a1", 64'(rdy_a), 64'h4);
        tick();
        chk("lock_out_a1", 64'(od_a), 64'hA1);
        data_a[23:16] = 8'hA2; last_a = 4'b0100;
        apply();
        chk("lock_grant_a2", 64'(grant_a), 64'h4);
        chk("lock_ready_a2", 64'(rdy_a), 64'h4);
        tick();
        chk("lock_out_a2", 64'(od_a), 64'hA2);
        vld_a = 4'b0001; last_a = 4'b0001;
        apply();
        chk("lock_ch0_ready", 64'(rdy_a), 64'h1);
        tick();
        chk("lock_ch0_out", 64'(od_a), 64'h5A);
        chk("lock_ch0_valid", 64'(ov_a), 64'h1);

        // Backpressure holding 0x5A while ch1 waits.
        vld_a = 4'b0010; last_a = 4'b0010; data_a[15:8] = 8'h77; ordy_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply();
            chk("bp_hold_data", 64'(od_a), 64'h5A);
            chk("bp_hold_valid", 64'(ov_a), 64'h1);
            chk("bp_ready_zero", 64'(rdy_a), 64'h0);
            tick();
        end
        chk("bp_hold_after", 64'(od_a), 64'h5A);
        ordy_a = 1'b1;
        apply();
        chk("bp_release_ready", 64'(rdy_a), 64'h2);
        tick();
        chk("bp_next_beat", 64'(od_a), 64'h77);
        vld_a = 4'b0000;
        apply();
        tick();
        chk("bp_drain", 64'(ov_a), 64'h0);

        // Stall in LOCK: ch1 locked then silent while ch2 waits.
        vld_a = 4'b0010; last_a = 4'b0000; data_a = {8'h00, 8'h42, 8'h41, 8'h00};
        cyc();
        vld_a = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            apply();
            chk("stall_ready_ch2", 64'(rdy_a[2]), 64'h0);
            chk("stall_grant", 64'(grant_a), 64'h2);
            chk("stall_busy", 64'(busy_a), 64'h1);
            tick();
            chk("stall_drained", 64'(ov_a), 64'h0);
        end
        vld_a = 4'b0110; last_a = 4'b0110; data_a[15:8] = 8'h43;
        apply();
        chk("stall_end_ready", 64'(rdy_a), 64'h2);
        tick();
        chk("stall_end_out", 64'(od_a), 64'h43);
        apply();
        chk("stall_ch2_ready", 64'(rdy_a), 64'h4);
        tick();
        chk("stall_ch2_out", 64'(od_a), 64'h42);
        vld_a = 4'b0000;

        // Asynchronous reset between beats 1 and 2 of a ch3 packet.
        vld_a = 4'b1000; last_a = 4'b0000; data_a[31:24] = 8'hD1;
        cyc();
        #1;
        CD = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 64'(ov_a), 64'h0);
        chk("rst_grant", 64'(grant_a), 64'h0);
        chk("rst_busy", 64'(busy_a), 64'h0);
        chk("rst_ready", 64'(rdy_a), 64'h0);
        chk("rst_data", 64'(od_a), 64'h0);
        vld_a = 4'hF; data_a = {8'hD2, 8'hC0, 8'hB0, 8'hE0};
        cyc();
        CD = 1'b1;
        apply();
        chk("rst_first_ready", 64'(rdy_a), 64'h1);
        chk("rst_no_stale_beat", 64'(ov_a), 64'h0);
        tick();
        chk("rst_first_out", 64'(od_a), 64'hE0);
        chk("rst_first_grant", 64'(grant_a), 64'h1);
        last_a = 4'b0001;
        cyc();
        vld_a = 4'b0000; last_a = 4'b0000;
        cyc();

        // SEL-driven instance: ch1 locked survives a SEL change.
        sel_b = 3'd1; vld_b = 5'b00010; last_b = 5'b00000;
        data_b = {8'h00, 8'h3C, 8'h00, 8'h31, 8'h00};
        apply();
        chk("sel_ready_ch1", 64'(rdy_b), 64'h2);
        tick();
        sel_b = 3'd3; vld_b = 5'b01010; last_b = 5'b01000; data_b[15:8] = 8'h32;
        apply();
        chk("sel_lock_ready", 64'(rdy_b), 64'h2);
        chk("sel_lock_grant", 64'(grant_b), 64'h2);
        tick();
        chk("sel_lock_out", 64'(od_b), 64'h32);
        data_b[15:8] = 8'h33; last_b = 5'b01010;
        apply();
        chk("sel_last_ready", 64'(rdy_b), 64'h2);
        tick();
        chk("sel_last_out", 64'(od_b), 64'h33);
        apply();
        chk("sel_ch3_ready", 64'(rdy_b), 64'h8);
        tick();
        chk("sel_ch3_out", 64'(od_b), 64'h3C);
        vld_b = 5'h1F; last_b = 5'h1F;
        for (int s = 5; s < 8; s++) begin
            sel_b = 3'(s);
            apply();
            chk("sel_oob_ready", 64'(rdy_b), 64'h0);
            tick();
            chk("sel_oob_valid", 64'(ov_b), 64'h0);
        end

        // Randomized traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            data_a = $urandom;
            data_b = {8'($urandom), 32'($urandom)};
            vld_a  = 4'($urandom);
            vld_b  = 5'($urandom);
            last_a = 4'($urandom) & 4'($urandom);
            last_b = 5'($urandom) & 5'($urandom);
            sel_a  = 2'($urandom);
            sel_b  = 3'($urandom);
            ordy_a = ($urandom_range(3, 0) != 0);
            ordy_b = ($urandom_range(3, 0) != 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
